// File: rtl/tile_sched_pkg.sv
// Shared state encoding and default parameters for the tile scheduler.
// The optional watchdog is enabled with TILE_SCHED_TIMEOUT_EN.
package tile_sched_pkg;

    localparam int DEF_ADDR_WIDTH     = 8;
    localparam int DEF_TILE_CNT_WIDTH = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ROUTE,
        WAIT_DONE,
        NEXT,
        FINISH
    } state_t;

endpackage

// File: rtl/tile_scheduler_rise.sv
// Rising-edge detector for the output-router done level.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/tile_scheduler.sv
// Sequences clear/route/wait steps per tile for the array controller.
// Define TILE_SCHED_TIMEOUT_EN to enable the WAIT_DONE watchdog and o_err.
module tile_scheduler
    import tile_sched_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int TILE_CNT_WIDTH = DEF_TILE_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic [TILE_CNT_WIDTH-1:0] i_tile_count,
    input  logic [ADDR_WIDTH-1:0]     i_route_size,
    input  logic                      i_or_done,
    output logic                      o_reg_clear,
    output logic                      o_route_en,
    output logic [ADDR_WIDTH-1:0]     o_route_size,
    output logic [TILE_CNT_WIDTH-1:0] o_tile_idx,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err
);

    state_t                    state;
    logic [TILE_CNT_WIDTH-1:0] tile_cnt;
    logic                      or_rise;

`ifdef TILE_SCHED_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign o_err = 1'b0;
`endif

    rise_detect u_rise (
        .clk   (i_clk),
        .rst   (i_rst),
        .level (i_or_done),
        .rise  (or_rise)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            tile_cnt     <= '0;
            o_reg_clear  <= 1'b0;
            o_route_en   <= 1'b0;
            o_route_size <= '0;
            o_tile_idx   <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
`ifdef TILE_SCHED_TIMEOUT_EN
            o_err        <= 1'b0;
            tmo_cnt      <= '0;
`endif
        end else begin
            o_reg_clear <= 1'b0;
            o_route_en  <= 1'b0;
            o_done      <= 1'b0;
            // Abort beats every other transition once a job is active.
            if (state != IDLE && i_abort) begin
                state       <= IDLE;
                o_busy      <= 1'b0;
                o_reg_clear <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (i_start && !i_abort) begin
                            if (i_tile_count != '0) begin
                                tile_cnt     <= i_tile_count;
                                o_route_size <= i_route_size;
                                o_tile_idx   <= '0;
                                o_reg_clear  <= 1'b1;
                                o_busy       <= 1'b1;
                                state        <= CLEAR;
`ifdef TILE_SCHED_TIMEOUT_EN
                                o_err        <= 1'b0;
`endif
                            end else begin
                                o_done <= 1'b1;
                            end
                        end
                    end
                    CLEAR: begin
                        o_route_en <= 1'b1;
                        state      <= ROUTE;
                    end
                    ROUTE: begin
                        state <= WAIT_DONE;
`ifdef TILE_SCHED_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                    WAIT_DONE: begin
                        if (or_rise) begin
                            state <= NEXT;
`ifdef TILE_SCHED_TIMEOUT_EN
                        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                            o_err  <= 1'b1;
                            o_done <= 1'b1;
                            state  <= FINISH;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
`endif
                        end
                    end
                    NEXT: begin
                        if (o_tile_idx == tile_cnt - TILE_CNT_WIDTH'(1)) begin
                            o_done <= 1'b1;
                            state  <= FINISH;
                        end else begin
                            o_tile_idx  <= o_tile_idx + 1'b1;
                            o_reg_clear <= 1'b1;
                            state       <= CLEAR;
                        end
                    end
                    FINISH: begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler: directed scenarios plus random jobs
// checked against a cycle-arithmetic schedule model.
module tb_tile_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abrt;
    logic [7:0] cnt;
    logic [7:0] rsz;
    logic       ordone;
    logic       reg_clear;
    logic       route_en;
    logic [7:0] route_size;
    logic [7:0] tile_idx;
    logic       busy;
    logic       done;
    logic       err;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int dly [256];

    int clr_q [$];
    int rte_q [$];
    int idx_q [$];
    int sz_q  [$];
    int done_q[$];

    tile_scheduler #(
        .ADDR_WIDTH     (8),
        .TILE_CNT_WIDTH (8),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_abort      (abrt),
        .i_tile_count (cnt),
        .i_route_size (rsz),
        .i_or_done    (ordone),
        .o_reg_clear  (reg_clear),
        .o_route_en   (route_en),
        .o_route_size (route_size),
        .o_tile_idx   (tile_idx),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reg_clear) clr_q.push_back(cyc);
        if (route_en) begin
            rte_q.push_back(cyc);
            idx_q.push_back(int'(tile_idx));
            sz_q.push_back(int'(route_size));
        end
        if (done) done_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clrq();
        clr_q.delete();
        rte_q.delete();
        idx_q.delete();
        sz_q.delete();
        done_q.delete();
    endtask

    // Model: tile k clears at C_k, routes at C_k+1; the done edge raised
    // D_k cycles after route lands the next clear (or o_done) at route+D_k+2.
    task automatic run_job(input int n, input int size);
        int s, k, raise_at, budget, limit, lo, ec;
        clrq();
        start = 1'b1;
        cnt = 8'(n);
        rsz = 8'(size);
        s = cyc;
        k = 0;
        raise_at = -1;
        budget = 0;
        lo = 0;
        limit = n * 20 + 50;
        tick();
        start = 1'b0;
        while (done_q.size() == 0 && budget < limit) begin
            ordone = (cyc == raise_at);
            if (!busy) lo++;
            if (route_en && k < 256) begin
                raise_at = cyc + dly[k];
                k++;
            end
            tick();
            budget++;
        end
        ordone = 1'b0;
        chk("job_budget", 32'(budget < limit), 1);
        chk("job_busy_low", lo, 0);
        chk("job_clr_cnt", clr_q.size(), n);
        chk("job_rte_cnt", rte_q.size(), n);
        chk("job_done_cnt", done_q.size(), 1);
        ec = s + 1;
        for (int i = 0; i < n && i < clr_q.size() && i < rte_q.size(); i++) begin
            chk("job_clr_cyc", clr_q[i], ec);
            chk("job_rte_cyc", rte_q[i], ec + 1);
            chk("job_idx", idx_q[i], i);
            chk("job_size", sz_q[i], size);
            ec = ec + 1 + dly[i] + 2;
        end
        if (done_q.size() > 0) chk("job_done_cyc", done_q[0], ec);
        chk("job_idle_busy", busy, 0);
        chk("job_idle_done", done, 0);
    endtask

    initial begin
        int s, e, e2, b, raise_at, n;
        rst = 1'b1;
        start = 1'b0;
        abrt = 1'b0;
        cnt = '0;
        rsz = '0;
        ordone = 1'b0;
        tick();
        tick();
        chk("rst_outs", {reg_clear, route_en, route_size, tile_idx, done, err}, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        tick();

        // Three tiles of size 16, done edge 10 cycles after each route.
        for (int i = 0; i < 256; i++) dly[i] = 10;
        run_job(3, 16);
        tick();

        // Zero tile count: immediate done, never busy.
        clrq();
        start = 1'b1;
        cnt = 8'd0;
        s = cyc;
        tick();
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_done_cyc", cyc, s + 1);
        b = 0;
        repeat (6) begin
            if (busy) b++;
            tick();
        end
        chk("zero_busy", b, 0);
        chk("zero_route", rte_q.size(), 0);
        chk("zero_done_cnt", done_q.size(), 1);

        // Done level already high before the job starts.
        clrq();
        ordone = 1'b1;
        repeat (3) tick();
        start = 1'b1;
        cnt = 8'd2;
        rsz = 8'd7;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk("hold_clr_cnt", clr_q.size(), 1);
        chk("hold_rte_cnt", rte_q.size(), 1);
        chk("hold_idx", tile_idx, 0);
        chk("hold_busy", busy, 1);
        ordone = 1'b0;
        tick();
        ordone = 1'b1;
        e = cyc;
        tick();
        repeat (12) tick();
        chk("hold_clr_cnt2", clr_q.size(), 2);
        if (clr_q.size() > 1) chk("hold_clr_cyc", clr_q[1], e + 2);
        if (rte_q.size() > 1) chk("hold_rte_cyc", rte_q[1], e + 3);
        if (idx_q.size() > 1) chk("hold_idx1", idx_q[1], 1);
        chk("hold_no_done", done_q.size(), 0);
        ordone = 1'b0;
        tick();
        ordone = 1'b1;
        e2 = cyc;
        tick();
        ordone = 1'b0;
        tick();
        tick();
        chk("hold_done_cnt", done_q.size(), 1);
        if (done_q.size() > 0) chk("hold_done_cyc", done_q[0], e2 + 2);
        chk("hold_idle", busy, 0);

        // Abort during tile 1 of 4, then a normal job.
        clrq();
        start = 1'b1;
        cnt = 8'd4;
        rsz = 8'd33;
        tick();
        start = 1'b0;
        raise_at = -1;
        b = 0;
        while (!(route_en && tile_idx == 8'd1) && b < 100) begin
            ordone = (cyc == raise_at);
            if (route_en) raise_at = cyc + 3;
            tick();
            b++;
        end
        ordone = 1'b0;
        chk("abort_reach", 32'(b < 100), 1);
        tick();
        tick();
        abrt = 1'b1;
        tick();
        abrt = 1'b0;
        chk("abort_clear", reg_clear, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick();
        chk("abort_clear_off", reg_clear, 0);
        repeat (20) tick();
        chk("abort_no_done", done_q.size(), 0);
        chk("abort_idle", busy, 0);
        for (int i = 0; i < 256; i++) dly[i] = $urandom_range(1, 12);
        run_job(3, 99);
        tick();

`ifdef TILE_SCHED_TIMEOUT_EN
        // Watchdog: no done edge, 32-cycle limit.
        clrq();
        start = 1'b1;
        cnt = 8'd1;
        rsz = 8'd5;
        s = cyc;
        tick();
        start = 1'b0;
        b = 0;
        while (!done && b < 200) begin
            tick();
            b++;
        end
        chk("tmo_reach", 32'(b < 200), 1);
        chk("tmo_cyc", cyc, s + 35);
        chk("tmo_err", err, 1);
        tick();
        chk("tmo_sticky", err, 1);
        chk("tmo_idle", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("tmo_err_clr", err, 0);
        abrt = 1'b1;
        tick();
        abrt = 1'b0;
        tick();
`else
        // No watchdog: wait indefinitely, o_err stays low.
        clrq();
        start = 1'b1;
        cnt = 8'd1;
        rsz = 8'd5;
        tick();
        start = 1'b0;
        repeat (100) tick();
        chk("notmo_err", err, 0);
        chk("notmo_busy", busy, 1);
        chk("notmo_done", done_q.size(), 0);
        abrt = 1'b1;
        tick();
        abrt = 1'b0;
        chk("notmo_abort", busy, 0);
        tick();
`endif

        // Reset in the middle of WAIT_DONE.
        start = 1'b1;
        cnt = 8'd2;
        rsz = 8'd44;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("midrst_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_outs", {reg_clear, route_en, route_size, tile_idx, done, err}, 0);
        chk("midrst_busy", busy, 0);
        tick();
        tick();
        chk("midrst_hold", {busy, reg_clear, route_en, route_size, tile_idx}, 0);
        rst = 1'b0;
        tick();

        // Start and abort together in IDLE.
        clrq();
        start = 1'b1;
        abrt = 1'b1;
        cnt = 8'd3;
        tick();
        start = 1'b0;
        abrt = 1'b0;
        repeat (5) tick();
        chk("sa_clr", clr_q.size(), 0);
        chk("sa_busy", busy, 0);
        chk("sa_done", done_q.size(), 0);

        // Random jobs.
        repeat (6) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < 256; i++) dly[i] = $urandom_range(1, 12);
            run_job(n, $urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) tick();
        end

        // Largest tile count must finish without index wrap.
        for (int i = 0; i < 256; i++) dly[i] = 1;
        run_job(255, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tile_scheduler.md
TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the route-size width.
REQ-002 Parameter TILE_CNT_WIDTH, default 8, SHALL set the tile-count and tile-index width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the watchdog limit in WAIT_DONE.
REQ-004 Port i_clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port i_rst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-006 Port i_start, input, 1, SHALL be the job start request, sampled only in IDLE.
REQ-007 Port i_abort, input, 1, SHALL be the job abort request.
REQ-008 Port i_tile_count, input, TILE_CNT_WIDTH, SHALL give the number of tiles in the job.
REQ-009 Port i_route_size, input, ADDR_WIDTH, SHALL give the per-tile route size.
REQ-010 Port i_or_done, input, 1, SHALL be the output-router done level from the array controller.
REQ-011 Ports o_reg_clear and o_route_en, output, 1 each, SHALL be single-cycle pulses to the array controller.
REQ-012 Port o_route_size, output, ADDR_WIDTH, SHALL carry the latched route size.
REQ-013 Port o_tile_idx, output, TILE_CNT_WIDTH, SHALL carry the index of the current tile.
REQ-014 Ports o_busy, o_done and o_err, output, 1 each: job active; 1-cycle completion pulse; sticky timeout flag.

Function
REQ-015 Every output SHALL be driven from a register.
REQ-016 The FSM SHALL have the states IDLE, CLEAR, ROUTE, WAIT_DONE, NEXT and FINISH.
REQ-017 In IDLE, i_start with nonzero i_tile_count SHALL latch the count and size, zero o_tile_idx, clear o_err and go to CLEAR.
REQ-018 In IDLE, i_start with i_tile_count==0 SHALL pulse o_done on the next cycle and stay in IDLE.
REQ-019 In CLEAR, o_reg_clear SHALL be high for exactly one cycle, then go to ROUTE.
REQ-020 In ROUTE, o_route_en SHALL be high for exactly one cycle, then go to WAIT_DONE.
REQ-021 Timing SHALL be: i_start at cycle N, o_reg_clear at N+1, o_route_en at N+2.
REQ-022 WAIT_DONE SHALL advance to NEXT only on a rising edge of i_or_done (low then high on consecutive samples); a level already high on entry SHALL be ignored.
REQ-023 In NEXT, if o_tile_idx==count-1 the FSM SHALL go to FINISH; otherwise it SHALL increment o_tile_idx and go to CLEAR.
REQ-024 In FINISH, o_done SHALL pulse for one cycle, then the FSM SHALL go to IDLE.
REQ-025 o_busy SHALL be high in every state except IDLE.
REQ-026 i_start while busy SHALL be ignored.
REQ-027 i_abort in any non-IDLE state SHALL pulse o_reg_clear, go to IDLE and suppress o_done.
REQ-028 i_abort together with i_start in IDLE SHALL win: no job starts.
REQ-029 A tile count of 2^TILE_CNT_WIDTH-1 SHALL complete without o_tile_idx wrapping.

Reset
REQ-030 While i_rst is high, the FSM SHALL be in IDLE and all outputs and counters SHALL be 0, including mid-job; the edge-detect history SHALL be 0.

Configuration
REQ-031 With TILE_SCHED_TIMEOUT_EN defined, a counter SHALL run in WAIT_DONE, clear on entry, and at TIMEOUT_CYCLES-1 without an i_or_done edge SHALL set o_err and go to FINISH.
REQ-032 Without TILE_SCHED_TIMEOUT_EN, o_err SHALL be tied to 0, WAIT_DONE SHALL wait indefinitely and no timeout counter SHALL exist.

Structure
REQ-033 The state enum and the default parameter constants SHALL live in the shared package tile_sched_pkg.
REQ-034 The i_or_done rising-edge detector SHALL be a sub-module named rise_detect.

Verification
REQ-035 Job of 3 tiles, size 16, i_or_done edge 10 cycles after each o_route_en -> 3 o_reg_clear/o_route_en pairs, o_tile_idx 0,1,2, o_route_size 16, one o_done.
REQ-036 i_tile_count=0 with i_start -> o_done at N+1, o_busy never high, no o_route_en.
REQ-037 i_or_done held high before the job starts, 2 tiles -> no advance until low then high again.
REQ-038 i_abort during tile 1 of 4 -> o_reg_clear pulse, IDLE next cycle, no o_done; a following start works normally.
REQ-039 With TILE_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=32, no i_or_done -> o_err high at the 32nd WAIT_DONE cycle, o_done pulse, o_err clears on next start.
REQ-040 i_rst asserted mid-WAIT_DONE -> all outputs 0 at once, IDLE; i_start and i_start+i_abort same cycle -> abort wins.
